// File: rtl/arcabuco_muldiv.sv
// arcabuco_muldiv: M-extension execute unit for the arcabuco core.
//
// Runs one multiply or divide at a time and hands one XLEN result to
// writeback through a valid/ready handshake.
//  - Multiplies (mul, mulh, mulhsu, mulhu) use a MUL_STAGES-deep pipelined
//    multiplier. The accept edge loads the first product register.
//  - Divides (div, divu, rem, remu) use a radix-2 restoring divider. The
//    accept edge is the setup step and loads the operand magnitudes. It is
//    followed by XLEN iteration cycles and one sign-fixup cycle.
//  - Some cases finish at the accept edge: a zero divisor, signed overflow
//    and the unused opcodes 8-15.
//
// Latency counts register edges from the accept edge inclusive:
//   mul-class MUL_STAGES, divide XLEN+2, early-out 1.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   kill_i       flush; drops any in-flight operation or pending result
//   in_valid_i   request valid
//   in_ready_o   unit idle and able to accept
//   op_i[3:0]    opcode: mul=0 mulh=1 mulhsu=2 mulhu=3 div=4 divu=5 rem=6 remu=7
//   a_i, b_i     rs1 / rs2 operands (XLEN bits)
//   out_valid_o  result valid
//   out_ready_i  writeback accepts the result
//   result_o     registered result (XLEN bits)
//
// Optional build macro ARCABUCO_MULDIV_OUT_BUFF_EN:
//   Adds one output register after the result mux. Every latency grows by
//   one cycle. kill_i also clears this register.
module arcabuco_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  // The last multiplier stage is the result register itself.
  // pipe_q therefore holds MUL_STAGES-1 full products.
  localparam int PIPE_N  = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(PIPE_N - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] pipe_q [PIPE_N];
  logic [2*XLEN-1:0] pipe_d [PIPE_N];
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept;
  logic              out_hs;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN+1:0] a_ext, b_ext;
  logic [2*XLEN-1:0] prod;
  logic              div_sgn, a_neg, b_neg, b_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     shifted;
  logic              div_ge;

  // mul keeps the low half of the product; mulh, mulhsu and mulhu keep the high half.
  function automatic logic [XLEN-1:0] mul_slice(input logic [1:0] op,
                                                input logic [2*XLEN-1:0] p);
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign in_ready_o = (state_q == IDLE);
  assign accept     = in_valid_i & in_ready_o & ~kill_i;
  assign out_hs     = out_valid_o & out_ready_i;

  // Operand conditioning.
  // Multiply operands are extended to 2*XLEN+2 bits, so that one signed
  // multiplier covers all four signedness variants. Only the low 2*XLEN
  // product bits are ever needed.
  // Divide operands are reduced to magnitudes. The early-out conditions are
  // also detected here.
  always_comb begin
    mul_a_sgn = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
    mul_b_sgn = (op_i[1:0] == 2'b01);
    a_ext     = {{(XLEN+2){mul_a_sgn & a_i[XLEN-1]}}, a_i};
    b_ext     = {{(XLEN+2){mul_b_sgn & b_i[XLEN-1]}}, b_i};
    prod      = (2*XLEN)'(a_ext * b_ext);

    div_sgn   = ~op_i[0];
    a_neg     = div_sgn & a_i[XLEN-1];
    b_neg     = div_sgn & b_i[XLEN-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
    b_zero    = (b_i == '0);
    div_ovf   = div_sgn & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);
  end

  // One restoring step.
  // The next dividend bit is shifted into the partial remainder. The divisor
  // is subtracted only when it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    div_ge  = (shifted >= {1'b0, dvs_q});
  end

  // Next-state and datapath control.
  // kill_i overrides every other transition.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    pipe_d    = pipe_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    res_d     = res_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op_i[1:0];
          if (op_i[3]) begin
            res_d   = '0;
            state_d = DONE;
          end else if (!op_i[2]) begin
            if (MUL_STAGES == 1) begin
              res_d   = mul_slice(op_i[1:0], prod);
              state_d = DONE;
            end else begin
              pipe_d[0] = prod;
              cnt_d     = '0;
              state_d   = MUL;
            end
          end else if (b_zero) begin
            res_d   = op_i[1] ? a_i : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            // MIN / -1 wraps back to MIN, and its remainder is zero.
            res_d   = op_i[1] ? '0 : a_i;
            state_d = DONE;
          end else begin
            quo_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            cnt_d     = '0;
            state_d   = DIV;
          end
        end
      end

      MUL: begin
        for (int i = 1; i < PIPE_N; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
        if (cnt_q == MUL_LAST) begin
          res_d   = mul_slice(op_q, pipe_q[PIPE_N-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DIV: begin
        if (cnt_q == DIV_LAST) begin
          if (op_q[1]) begin
            res_d = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
          end else begin
            res_d = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
          end
          state_d = DONE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], div_ge};
          rem_d = div_ge ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (kill_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      pipe_q    <= '{default: '0};
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      pipe_q    <= pipe_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      res_q     <= res_d;
    end
  end

`ifdef ARCABUCO_MULDIV_OUT_BUFF_EN
  logic [XLEN-1:0] buf_q, buf_d;
  logic            vld_q, vld_d;

  // The buffer copies res_q every cycle. res_q only changes on entry to
  // DONE, so the buffered result stays stable while vld_q is high.
  // vld_q trails the DONE state by one cycle.
  always_comb begin
    buf_d = res_q;
    vld_d = (state_q == DONE) & ~out_hs;
    if (kill_i) begin
      buf_d = '0;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      vld_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      vld_q <= vld_d;
    end
  end

  assign result_o    = buf_q;
  assign out_valid_o = vld_q;
`else
  assign result_o    = res_q;
  assign out_valid_o = (state_q == DONE);
`endif

endmodule

// File: tb/tb_arcabuco_muldiv.sv
// Scoreboard bench for arcabuco_muldiv.
//
// The driver pushes each expected result into a queue, together with the
// cycle on which out_valid_o must first rise. An independent monitor
// compares the results and latencies whenever the DUT presents an output.
// Inputs change #1 after the rising edge. The monitor samples on the
// falling edge.
module tb_arcabuco_muldiv;

  localparam int XLEN = 32;
`ifdef ARCABUCO_MULDIV_OUT_BUFF_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LM = 2 + EXTRA;
  localparam int LD = 34 + EXTRA;
  localparam int LE = 1 + EXTRA;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            kill_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;

  arcabuco_muldiv #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kill_i      (kill_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          exp_cyc;
    int          id;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   valid_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  // Monitor.
  // The first rising edge of out_valid_o is checked against the expected
  // cycle. The result is checked on the handshake cycle, and the entry is
  // then popped.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_seen = 1'b0;
    end else if (out_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid actual=1 expected=0 result=0x%08h", result_o);
      end else begin
        if (!valid_seen) begin
          checkOutput($sformatf("latency_txn%0d", sb[0].id), cyc, sb[0].exp_cyc);
          valid_seen = 1'b1;
        end
        if (out_ready_i) begin
          checkOutput($sformatf("result_txn%0d", sb[0].id), result_o, sb[0].res);
          void'(sb.pop_front());
          valid_seen = 1'b0;
        end
      end
    end
  end

  // Driver.
  // Holds the request until in_ready_o is seen, then records the expected
  // response. The accept edge ends the cycle whose counter value is cyc,
  // so the first valid cycle is cyc + lat.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res,
                               input int lat, input int id);
    bit ok = 1'b0;
    exp_t e;
    in_valid_i = 1'b1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (in_ready_o && !kill_i) ok = 1'b1;
    end
    if (!ok) begin
      timeoutFail($sformatf("accept_txn%0d", id));
      in_valid_i = 1'b0;
      return;
    end
    e.res = res;
    e.exp_cyc = cyc + lat;
    e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeoutFail("drain");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [19];

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    bit seen;
    vecs = '{
      '{4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LM},
      '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LM},
      '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LM},
      '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LM},
      '{4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, LM},
      '{4'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, LM},
      '{4'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LD},
      '{4'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LD},
      '{4'd5, 32'd100,       32'd7,         32'd14,        LD},
      '{4'd7, 32'd100,       32'd7,         32'd2,         LD},
      '{4'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LD},
      '{4'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, LD},
      '{4'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, LE},
      '{4'd6, 32'd5,         32'd0,         32'd5,         LE},
      '{4'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, LE},
      '{4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LE},
      '{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LE},
      '{4'd8, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, LE},
      '{4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LD}
    };

    rst_n = 1'b0;
    kill_i = 1'b0;
    in_valid_i = 1'b0;
    op_i = '0;
    a_i = '0;
    b_i = '0;
    out_ready_i = 1'b1;
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i);
    end
    waitDrain(200);

    // Backpressure: hold a finished mulhu result for ten cycles.
    out_ready_i = 1'b0;
    applyStimulus(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LM, 100);
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    if (!seen) timeoutFail("bp_valid");
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_result", result_o, 32'hFFFF_FFFE);
      checkOutput("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
    waitDrain(20);

    // Kill a divide in its fifteenth cycle.
    applyStimulus(4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LD, 200);
    repeat (13) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    sb.delete();
    checkOutput("kill_in_ready", {31'd0, in_ready_o}, 32'd1);
    seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    checkOutput("kill_no_valid", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(4'd0, 32'd3, 32'd4, 32'd12, LM, 201);
    waitDrain(20);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(4'd5, 32'd100, 32'd7, 32'd14, LD, 300);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'd0, 32'd6, 32'd7, 32'd42, LM, 301);
    waitDrain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
